// File: rtl/execute_md.sv
// Execute stage: operand muxes, single-cycle ALU, iterative multiply/divide
// unit owning HI/LO, and the registered EX/MEM output stage.
//
// Handshake: an instruction is taken when in_valid is high, stall_o is low
// and flush is low. While stall_o is high the upstream stage must hold every
// input stable. The unit stalls only instructions that touch HI/LO or start a
// new multiply/divide. Independent ALU work keeps flowing while it is busy.
module execute_md #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  flush,
  input  logic [1:0]            aluin1_i,
  input  logic                  aluin2_i,
  input  logic [3:0]            alusel_i,
  input  logic [DW-1:0]         rd1_i,
  input  logic [DW-1:0]         rd2_i,
  input  logic [DW-1:0]         imm_ext_i,
  input  logic [DW-1:0]         sa_ext_i,
  input  logic [AW-1:0]         rt_i,
  input  logic [AW-1:0]         rd_i,
  input  logic                  cregwa_i,
  input  logic                  regwe_i,
  input  logic [2:0]            mdop_i,
  input  logic [1:0]            mfsel_i,
  output logic                  stall_o,
  output logic                  out_valid,
  output logic [DW-1:0]         result_o,
  output logic [AW-1:0]         wa_o,
  output logic                  we_o,
  output logic [DW-1:0]         hi_o,
  output logic [DW-1:0]         lo_o,
  output logic                  o_dbg_state,
  output logic [$clog2(DW):0]   o_dbg_cnt
);

  localparam int SW = $clog2(DW);
  localparam logic [SW:0]   CNT_ONE  = (SW+1)'(1);
  localparam logic [SW:0]   CNT_INIT = (SW+1)'(DW);
  localparam logic [DW-1:0] C16      = DW'(16);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_busy;

  // Control decode
  logic w_md_start;   // MULT/MULTU/DIV/DIVU
  logic w_md_any;     // any HI/LO-touching md op (includes MTHI/MTLO)
  logic w_mf;         // MFHI/MFLO
  logic w_accept;
  logic w_issue;
  logic w_signed;

  // ALU
  logic [DW-1:0] w_op1;
  logic [DW-1:0] w_op2;
  logic [DW-1:0] w_alu;
  logic [DW-1:0] w_result;

  // Mult/div datapath registers
  logic [DW-1:0] r_acc;     // partial product high half, or remainder
  logic [DW-1:0] r_q;       // multiplier being shifted out, or quotient
  logic [DW-1:0] r_b;       // multiplicand or divisor magnitude
  logic [SW:0]   r_cnt;
  logic          r_is_div;
  logic          r_neg_q;   // negate product / quotient at the end
  logic          r_neg_r;   // negate remainder at the end
  logic          r_dz;      // divide by zero
  logic [DW-1:0] r_hi;
  logic [DW-1:0] r_lo;

  // Output stage registers
  logic          r_out_valid;
  logic          r_we;
  logic [AW-1:0] r_wa;
  logic [DW-1:0] r_result;

  // Step datapath
  logic [DW-1:0]   w_a_mag;
  logic [DW-1:0]   w_b_mag;
  logic [DW:0]     w_mul_sum;
  logic [DW:0]     w_rem_sh;
  logic            w_ge;
  logic [DW-1:0]   w_acc_nxt;
  logic [DW-1:0]   w_q_nxt;
  logic [2*DW-1:0] w_prod;
  logic [2*DW-1:0] w_prod_fin;
  logic [DW-1:0]   w_quo_fin;
  logic [DW-1:0]   w_rem_fin;
  logic [DW-1:0]   w_hi_fin;
  logic [DW-1:0]   w_lo_fin;
  logic            w_last;

  // Decode, stall and accept
  always_comb begin
    w_md_start = (mdop_i >= 3'd1) && (mdop_i <= 3'd4);
    w_md_any   = (mdop_i >= 3'd1) && (mdop_i <= 3'd6);
    w_mf       = (mfsel_i == 2'd1) || (mfsel_i == 2'd2);
    w_signed   = (mdop_i == 3'd1) || (mdop_i == 3'd3);
    stall_o    = in_valid & w_busy & (w_md_any | w_mf);
    w_accept   = in_valid & ~stall_o & ~flush;
    w_issue    = w_accept & w_md_start;
    w_last     = w_busy && (r_cnt == CNT_ONE);
  end

  // Operand muxes and ALU
  always_comb begin
    w_op1 = '0;
    case (aluin1_i)
      2'd0:    w_op1 = rd1_i;
      2'd1:    w_op1 = sa_ext_i;
      2'd2:    w_op1 = C16;
      default: w_op1 = '0;
    endcase
    w_op2 = aluin2_i ? imm_ext_i : rd2_i;
    w_alu = '0;
    case (alusel_i)
      4'd0:    w_alu = w_op1 + w_op2;
      4'd1:    w_alu = w_op1 - w_op2;
      4'd2:    w_alu = w_op1 & w_op2;
      4'd3:    w_alu = w_op1 | w_op2;
      4'd4:    w_alu = w_op1 ^ w_op2;
      4'd5:    w_alu = ~(w_op1 | w_op2);
      4'd6:    w_alu = {{(DW-1){1'b0}}, ($signed(w_op1) < $signed(w_op2))};
      4'd7:    w_alu = {{(DW-1){1'b0}}, (w_op1 < w_op2)};
      4'd8:    w_alu = w_op2 << w_op1[SW-1:0];
      4'd9:    w_alu = w_op2 >> w_op1[SW-1:0];
      4'd10:   w_alu = $signed(w_op2) >>> w_op1[SW-1:0];
      4'd11:   w_alu = w_op2 << w_op1;
      default: w_alu = '0;
    endcase
    case (mfsel_i)
      2'd1:    w_result = r_hi;
      2'd2:    w_result = r_lo;
      default: w_result = w_alu;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // FSM next state: leave IDLE on issue, return after the final step
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_issue) w_state_nxt = S_BUSY;
      S_BUSY:  if (r_cnt == CNT_ONE) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_busy      = (r_state == S_BUSY);
    o_dbg_state = r_state;
    o_dbg_cnt   = r_cnt;
  end

  // One radix-2 step: shift-add multiply or restoring divide, plus the
  // sign-corrected final values used on the last step
  always_comb begin
    w_a_mag   = (w_signed && rd1_i[DW-1]) ? -rd1_i : rd1_i;
    w_b_mag   = (w_signed && rd2_i[DW-1]) ? -rd2_i : rd2_i;
    w_mul_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);
    w_rem_sh  = {r_acc, r_q[DW-1]};
    w_ge      = (w_rem_sh >= {1'b0, r_b});
    if (r_is_div) begin
      // A remainder that fails the trial is below the divisor, so it fits DW bits.
      w_acc_nxt = w_ge ? (w_rem_sh[DW-1:0] - r_b) : w_rem_sh[DW-1:0];
      w_q_nxt   = {r_q[DW-2:0], w_ge};
    end else begin
      w_acc_nxt = w_mul_sum[DW:1];
      w_q_nxt   = {w_mul_sum[0], r_q[DW-1:1]};
    end
    w_prod     = {w_acc_nxt, w_q_nxt};
    w_prod_fin = r_neg_q ? -w_prod : w_prod;
    // With a zero divisor every trial succeeds, so the remainder is the
    // dividend magnitude; only the quotient needs forcing to all-ones.
    w_quo_fin  = r_dz ? '1 : (r_neg_q ? -w_q_nxt : w_q_nxt);
    w_rem_fin  = r_neg_r ? -w_acc_nxt : w_acc_nxt;
    if (r_is_div) begin
      w_hi_fin = w_rem_fin;
      w_lo_fin = w_quo_fin;
    end else begin
      w_hi_fin = w_prod_fin[2*DW-1:DW];
      w_lo_fin = w_prod_fin[DW-1:0];
    end
  end

  // Mult/div operand latch on issue, then one step per cycle while busy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc    <= '0;
      r_q      <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
    end else if (w_issue) begin
      r_acc    <= '0;
      r_q      <= w_a_mag;
      r_b      <= w_b_mag;
      r_cnt    <= CNT_INIT;
      r_is_div <= (mdop_i == 3'd3) || (mdop_i == 3'd4);
      r_neg_q  <= w_signed & (rd1_i[DW-1] ^ rd2_i[DW-1]);
      r_neg_r  <= w_signed & rd1_i[DW-1];
      r_dz     <= (rd2_i == '0);
    end else if (w_busy) begin
      r_acc    <= w_acc_nxt;
      r_q      <= w_q_nxt;
      r_cnt    <= r_cnt - CNT_ONE;
    end
  end

  // HI/LO: written by the final step or by an accepted MTHI/MTLO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_last) begin
      r_hi <= w_hi_fin;
      r_lo <= w_lo_fin;
    end else if (w_accept && mdop_i == 3'd5) begin
      r_hi <= rd1_i;
    end else if (w_accept && mdop_i == 3'd6) begin
      r_lo <= rd1_i;
    end
  end

  // EX/MEM output register; result and address hold when nothing is taken
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_we        <= 1'b0;
      r_wa        <= '0;
      r_result    <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_we        <= regwe_i;
      r_wa        <= cregwa_i ? rd_i : rt_i;
      r_result    <= w_result;
    end else begin
      r_out_valid <= 1'b0;
      r_we        <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign we_o      = r_we;
  assign wa_o      = r_wa;
  assign result_o  = r_result;
  assign hi_o      = r_hi;
  assign lo_o      = r_lo;

endmodule

// File: tb/tb_execute_md.sv
// Bench for execute_md: directed and random ALU / mult / div sequences
// compared against an arithmetic model of HI, LO and ALU results.
module tb_execute_md;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, flush;
  logic [1:0]    aluin1_i;
  logic          aluin2_i;
  logic [3:0]    alusel_i;
  logic [DW-1:0] rd1_i, rd2_i, imm_ext_i, sa_ext_i;
  logic [AW-1:0] rt_i, rd_i;
  logic          cregwa_i, regwe_i;
  logic [2:0]    mdop_i;
  logic [1:0]    mfsel_i;
  logic          stall_o, out_valid, we_o;
  logic [DW-1:0] result_o, hi_o, lo_o;
  logic [AW-1:0] wa_o;
  logic          o_dbg_state;
  logic [5:0]    o_dbg_cnt;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] m_hi = '0;
  logic [DW-1:0] m_lo = '0;

  // clock
  always #5 clk = ~clk;

  execute_md #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
    .aluin1_i(aluin1_i), .aluin2_i(aluin2_i), .alusel_i(alusel_i),
    .rd1_i(rd1_i), .rd2_i(rd2_i), .imm_ext_i(imm_ext_i), .sa_ext_i(sa_ext_i),
    .rt_i(rt_i), .rd_i(rd_i), .cregwa_i(cregwa_i), .regwe_i(regwe_i),
    .mdop_i(mdop_i), .mfsel_i(mfsel_i), .stall_o(stall_o),
    .out_valid(out_valid), .result_o(result_o), .wa_o(wa_o), .we_o(we_o),
    .hi_o(hi_o), .lo_o(lo_o), .o_dbg_state(o_dbg_state), .o_dbg_cnt(o_dbg_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ins();
    in_valid = 0; flush = 0; aluin1_i = 0; aluin2_i = 0; alusel_i = 0;
    rd1_i = 0; rd2_i = 0; imm_ext_i = 0; sa_ext_i = 0; rt_i = 0; rd_i = 0;
    cregwa_i = 0; regwe_i = 0; mdop_i = 0; mfsel_i = 0;
  endtask

  // Reference ALU from the operation table
  function automatic logic [DW-1:0] m_alu(input logic [3:0] sel,
                                          input logic [DW-1:0] a, input logic [DW-1:0] b);
    int unsigned sh;
    logic [DW-1:0] r;
    sh = a % 32;
    r = 0;
    case (sel)
      0: r = a + b;
      1: r = a - b;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = ~(a | b);
      6: r = (int'(a) < int'(b)) ? 1 : 0;
      7: r = (a < b) ? 1 : 0;
      8: r = b * (64'd1 << sh);
      9: r = b / (64'd1 << sh);
      10: r = 32'(int'(b) >>> sh);
      11: r = (a >= 32) ? 0 : b * (64'd1 << a);
      default: r = 0;
    endcase
    return r;
  endfunction

  // Reference HI/LO update for MULT/MULTU/DIV/DIVU
  task automatic md_model(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint p;
    logic [63:0] pu;
    int q, r;
    case (op)
      1: begin p = longint'(int'(a)) * longint'(int'(b)); {m_hi, m_lo} = p; end
      2: begin pu = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = pu; end
      3: begin
        if (b == 0) begin m_lo = '1; m_hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin m_lo = a; m_hi = 0; end
        else begin q = int'(a) / int'(b); r = int'(a) % int'(b); m_lo = q; m_hi = r; end
      end
      default: begin
        if (b == 0) begin m_lo = '1; m_hi = a; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
    endcase
  endtask

  task automatic alu_step(input string tag, input logic [1:0] s1, input logic s2, input logic [3:0] sel,
                          input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] imm, input logic [DW-1:0] sa);
    logic [DW-1:0] op1, op2, exp;
    logic [AW-1:0] exp_wa;
    clear_ins();
    in_valid = 1; aluin1_i = s1; aluin2_i = s2; alusel_i = sel;
    rd1_i = a; rd2_i = b; imm_ext_i = imm; sa_ext_i = sa;
    regwe_i = 1'($urandom_range(0, 1)); cregwa_i = 1'($urandom_range(0, 1));
    rt_i = AW'($urandom); rd_i = AW'($urandom);
    mfsel_i = ($urandom_range(0, 3) == 0) ? 2'd3 : 2'd0;
    op1 = (s1 == 0) ? a : (s1 == 1) ? sa : (s1 == 2) ? 32'd16 : 32'd0;
    op2 = s2 ? imm : b;
    exp = m_alu(sel, op1, op2);
    exp_wa = cregwa_i ? rd_i : rt_i;
    #1;
    check({tag, ".stall"}, stall_o, 0);
    tick();
    check({tag, ".valid"}, out_valid, 1);
    check({tag, ".result"}, result_o, exp);
    check({tag, ".wa"}, wa_o, exp_wa);
    check({tag, ".we"}, we_o, regwe_i);
    clear_ins();
  endtask

  // MFLO then MFHI, expecting the MFLO to be held for exp_stall cycles
  task automatic mf_wait(input string tag, input int exp_stall);
    int n;
    logic [AW-1:0] rt;
    clear_ins();
    rt = AW'($urandom);
    in_valid = 1; mfsel_i = 2; regwe_i = 1; rt_i = rt;
    #1;
    n = 0;
    while (stall_o && n < 200) begin tick(); n++; end
    check({tag, ".stall_cycles"}, n, exp_stall);
    tick();
    check({tag, ".mflo_valid"}, out_valid, 1);
    check({tag, ".mflo"}, result_o, m_lo);
    check({tag, ".mflo_wa"}, wa_o, rt);
    check({tag, ".lo_o"}, lo_o, m_lo);
    check({tag, ".hi_o"}, hi_o, m_hi);
    mfsel_i = 1;
    #1;
    check({tag, ".mfhi_stall"}, stall_o, 0);
    tick();
    check({tag, ".mfhi"}, result_o, m_hi);
    clear_ins();
  endtask

  // Present a mult/div (waiting pre_stall cycles), retire it, then read HI/LO
  task automatic md_run(input string tag, input logic [2:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input int pre_stall);
    int n;
    clear_ins();
    in_valid = 1; mdop_i = op; rd1_i = a; rd2_i = b;
    #1;
    n = 0;
    while (stall_o && n < 200) begin tick(); n++; end
    check({tag, ".pre_stall"}, n, pre_stall);
    check({tag, ".prev_hi"}, hi_o, m_hi);
    check({tag, ".prev_lo"}, lo_o, m_lo);
    tick();
    md_model(op, a, b);
    check({tag, ".retire_valid"}, out_valid, 1);
    check({tag, ".retire_we"}, we_o, 0);
    check({tag, ".busy"}, o_dbg_state, 1);
    check({tag, ".cnt"}, o_dbg_cnt, DW);
    mf_wait(tag, DW);
  endtask

  task automatic issue_md(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    clear_ins();
    in_valid = 1; mdop_i = op; rd1_i = a; rd2_i = b;
    tick();
    md_model(op, a, b);
    clear_ins();
  endtask

  initial begin
    logic [DW-1:0] a, b;
    logic [2:0] op;
    // reset
    clear_ins();
    rst = 0;
    #1;
    check("rst.valid", out_valid, 0);
    check("rst.result", result_o, 0);
    check("rst.wa", wa_o, 0);
    check("rst.we", we_o, 0);
    check("rst.hi", hi_o, 0);
    check("rst.lo", lo_o, 0);
    check("rst.state", o_dbg_state, 0);
    check("rst.cnt", o_dbg_cnt, 0);
    tick(); tick();
    rst = 1;
    tick();

    // directed ALU
    alu_step("add_wrap", 0, 1, 0, 32'h7FFF_FFFF, 0, 32'h1, 0);
    check("add_wrap.value", result_o, 32'h8000_0000);
    alu_step("sra", 1, 0, 10, 0, 32'h8000_0000, 0, 32'd4);
    check("sra.value", result_o, 32'hF800_0000);
    alu_step("lui", 2, 1, 11, 0, 0, 32'h1234, 0);
    check("lui.value", result_o, 32'h1234_0000);

    // random ALU
    for (int i = 0; i < 40; i++) begin
      alu_step("alu_rand", 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), $urandom, $urandom, $urandom,
               ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom);
    end

    // MULT -3 x 7 with an independent ADD slipping past
    issue_md(1, 32'hFFFF_FFFD, 32'd7);
    check("mult.busy", o_dbg_state, 1);
    alu_step("add_during_busy", 0, 0, 0, 32'd5, 32'd6, 0, 0);
    check("add_during_busy.value", result_o, 32'd11);
    mf_wait("mult_neg", DW - 1);
    check("mult_neg.lo", lo_o, 32'hFFFF_FFEB);
    check("mult_neg.hi", hi_o, 32'hFFFF_FFFF);

    // directed divides
    md_run("div_neg", 3, 32'hFFFF_FFF9, 32'd2, 0);
    check("div_neg.lo", lo_o, 32'hFFFF_FFFD);
    check("div_neg.hi", hi_o, 32'hFFFF_FFFF);
    md_run("divu_zero", 4, 32'd7, 32'd0, 0);
    check("divu_zero.lo", lo_o, 32'hFFFF_FFFF);
    check("divu_zero.hi", hi_o, 32'd7);
    md_run("div_ovf", 3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("div_ovf.lo", lo_o, 32'h8000_0000);
    check("div_ovf.hi", hi_o, 32'd0);
    md_run("div_zero_neg", 3, 32'hFFFF_FF00, 32'd0, 0);

    // random mult/div
    for (int i = 0; i < 10; i++) begin
      op = 3'($urandom_range(1, 4));
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 2) == 0) b = 32'($urandom_range(1, 20)) * (($urandom_range(0, 1) == 0) ? 1 : -1);
      md_run("md_rand", op, a, b, 0);
    end

    // flush on a DIVU issue: nothing starts, nothing retires
    clear_ins();
    in_valid = 1; flush = 1; mdop_i = 4; rd1_i = 32'd100; rd2_i = 32'd3;
    #1;
    check("flush_issue.stall", stall_o, 0);
    tick();
    check("flush_issue.valid", out_valid, 0);
    check("flush_issue.we", we_o, 0);
    check("flush_issue.busy", o_dbg_state, 0);
    check("flush_issue.hi", hi_o, m_hi);
    check("flush_issue.lo", lo_o, m_lo);

    // flush while busy does not abort the operation
    issue_md(2, 32'hDEAD_BEEF, 32'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      clear_ins();
      in_valid = 1; flush = 1; mfsel_i = 2;
      #1;
      check("flush_busy.stall", stall_o, 1);
      tick();
      check("flush_busy.valid", out_valid, 0);
      check("flush_busy.state", o_dbg_state, 1);
    end
    clear_ins();
    in_valid = 1; flush = 1; alusel_i = 0; regwe_i = 1;
    tick();
    check("flush_alu.valid", out_valid, 0);
    check("flush_alu.we", we_o, 0);
    mf_wait("flush_busy", DW - 4);

    // MTHI / MTLO then immediate reads
    clear_ins();
    in_valid = 1; mdop_i = 5; rd1_i = 32'hA5A5_A5A5;
    tick();
    m_hi = 32'hA5A5_A5A5;
    check("mthi.hi", hi_o, 32'hA5A5_A5A5);
    a = $urandom;
    clear_ins();
    in_valid = 1; mdop_i = 6; rd1_i = a;
    tick();
    m_lo = a;
    mf_wait("mtlo_mfhi", 0);

    // back-to-back MULTU: the second waits for the first
    issue_md(2, $urandom, $urandom);
    md_run("b2b", 2, $urandom, $urandom, DW);

    // reset in the middle of a MULT
    issue_md(1, $urandom, $urandom);
    repeat (5) tick();
    rst = 0;
    #1;
    m_hi = 0; m_lo = 0;
    check("rst_mid.valid", out_valid, 0);
    check("rst_mid.result", result_o, 0);
    check("rst_mid.wa", wa_o, 0);
    check("rst_mid.we", we_o, 0);
    check("rst_mid.hi", hi_o, 0);
    check("rst_mid.lo", lo_o, 0);
    check("rst_mid.state", o_dbg_state, 0);
    check("rst_mid.cnt", o_dbg_cnt, 0);
    tick();
    rst = 1;
    tick();
    mf_wait("after_rst", 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
